uart_ascii_rx: RTL and testbench

8N1 UART receiver that turns a serial line into ASCII bytes for the ASCII-to-seven-segment decoder directly downstream. It holds the last accepted character on a stable 8-bit bus that drives the decoder. It also pulses a one-cycle strobe per accepted byte. Sits between the board RX pin and the display path.

---
 rtl/uart_pkg.sv | 24 ++
 rtl/sync_2ff.sv | 25 ++
 rtl/uart_ascii_rx.sv | 148 ++++++++++++++
 tb/tb_uart_ascii_rx.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART types and constants: FSM states, clocks-per-bit helper, ASCII digit bounds.
// The ASCII-to-seven-segment decoder bench uses the digit bounds as well.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BREAK
  } state_t;

  localparam logic [7:0] ASCII_ZERO = 8'h30;
  localparam logic [7:0] ASCII_NINE = 8'h39;

  function automatic int cpb(input int clk_hz, input int baud);
    return clk_hz / baud;
  endfunction

  function automatic logic is_digit(input logic [7:0] c);
    return (c >= ASCII_ZERO) && (c <= ASCII_NINE);
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for the idle-high RX pin; resets to 1 so no start is seen out of reset.
// Latency 2 cycles, no backpressure.
module sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_meta <= 1'b1;
      r_sync <= 1'b1;
    end else begin
      r_meta <= d;
      r_sync <= r_meta;
    end
  end

  assign q = r_sync;

endmodule

// File: rtl/uart_ascii_rx.sv
// 8N1 UART receiver holding the last accepted ASCII byte for the seven-segment decoder.
// valid pulses the edge after the stop-bit sample; no backpressure, the downstream must keep up.
module uart_ascii_rx
  import uart_pkg::*;
#(
  parameter int unsigned CLK_HZ      = 50_000_000,
  parameter int unsigned BAUD        = 9600,
  parameter bit          DIGITS_ONLY = 1'b0,
  parameter logic [7:0]  RESET_CHAR  = 8'h30
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic [7:0] ascii,
  output logic       valid,
  output logic       frame_err,
  output logic       busy
);

  localparam int CPB  = cpb(CLK_HZ, BAUD);
  localparam int HALF = CPB / 2;
  localparam int TW   = (CPB < 4) ? 2 : $clog2(CPB);

  localparam logic [TW-1:0] TICK_HALF = TW'(HALF - 1);
  localparam logic [TW-1:0] TICK_END  = TW'(CPB - 1);

  if (CPB < 4) begin : g_cpb_check
    $error("uart_ascii_rx: CLK_HZ/BAUD must be at least 4");
  end

  logic          w_rxs;
  logic          w_accept;
  state_t        r_state,  w_state_nxt;
  logic [TW-1:0] r_tick,   w_tick_nxt;
  logic [2:0]    r_bit,    w_bit_nxt;
  logic [7:0]    r_shift,  w_shift_nxt;
  logic [7:0]    r_ascii,  w_ascii_nxt;
  logic          r_valid,  w_valid_nxt;
  logic          r_ferr,   w_ferr_nxt;

  sync_2ff u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (rx),
    .q     (w_rxs)
  );

  assign w_accept = DIGITS_ONLY ? is_digit(r_shift) : 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_tick  <= '0;
      r_bit   <= '0;
      r_shift <= '0;
      r_ascii <= RESET_CHAR;
      r_valid <= 1'b0;
      r_ferr  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_tick  <= w_tick_nxt;
      r_bit   <= w_bit_nxt;
      r_shift <= w_shift_nxt;
      r_ascii <= w_ascii_nxt;
      r_valid <= w_valid_nxt;
      r_ferr  <= w_ferr_nxt;
    end
  end

  // Tick restarts from zero on every state change and every sample point.
  always_comb begin
    w_state_nxt = r_state;
    w_tick_nxt  = r_tick + 1'b1;
    w_bit_nxt   = r_bit;
    w_shift_nxt = r_shift;
    w_ascii_nxt = r_ascii;
    w_valid_nxt = 1'b0;
    w_ferr_nxt  = r_ferr;

    case (r_state)
      IDLE: begin
        w_tick_nxt = '0;
        if (!w_rxs) begin
          w_state_nxt = START;
        end
      end

      START: begin
        if (r_tick == TICK_HALF) begin
          w_tick_nxt = '0;
          if (!w_rxs) begin
            w_state_nxt = DATA;
            w_bit_nxt   = '0;
          end else begin
            w_state_nxt = IDLE;
          end
        end
      end

      DATA: begin
        if (r_tick == TICK_END) begin
          w_tick_nxt  = '0;
          w_shift_nxt = {w_rxs, r_shift[7:1]};
          w_bit_nxt   = r_bit + 3'd1;
          if (r_bit == 3'd7) begin
            w_state_nxt = STOP;
          end
        end
      end

      STOP: begin
        if (r_tick == TICK_END) begin
          w_tick_nxt = '0;
          if (w_rxs) begin
            w_ferr_nxt  = 1'b0;
            w_state_nxt = IDLE;
            if (w_accept) begin
              w_ascii_nxt = r_shift;
              w_valid_nxt = 1'b1;
            end
          end else begin
            w_ferr_nxt  = 1'b1;
            w_state_nxt = BREAK;
          end
        end
      end

      BREAK: begin
        // A line held low must go high before another start can be detected.
        w_tick_nxt = '0;
        if (w_rxs) begin
          w_state_nxt = IDLE;
        end
      end

      default: begin
        w_tick_nxt  = '0;
        w_state_nxt = IDLE;
      end
    endcase
  end

  assign ascii     = r_ascii;
  assign valid     = r_valid;
  assign frame_err = r_ferr;
  assign busy      = (r_state != IDLE);

endmodule

// File: tb/tb_uart_ascii_rx.sv
// Bench for uart_ascii_rx: two instances (all bytes / digits only) share one RX line and reset,
// checked against a frame-level model of what each should hold after every frame.
module tb_uart_ascii_rx;

  localparam int CLK_HZ = 1_000_000;
  localparam int BAUD   = 100_000;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx    = 1'b1;
  logic [7:0] ascii_o [2];
  logic [1:0] valid_o;
  logic [1:0] ferr_o;
  logic [1:0] busy_o;

  int n_chk = 0;
  int n_bad = 0;
  int cyc   = 0;

  int         pulses     [2] = '{0, 0};
  int         last_pulse [2] = '{0, 0};
  logic [1:0] prev_v         = '0;

  logic [7:0] exp_ascii  [2] = '{8'h30, 8'h30};
  bit         exp_ferr   [2] = '{1'b0, 1'b0};
  int         exp_pulses [2] = '{0, 0};

  uart_ascii_rx #(
    .CLK_HZ      (CLK_HZ),
    .BAUD        (BAUD),
    .DIGITS_ONLY (1'b0),
    .RESET_CHAR  (8'h30)
  ) u_dut_all (
    .clk       (clk),
    .rst_n     (rst_n),
    .rx        (rx),
    .ascii     (ascii_o[0]),
    .valid     (valid_o[0]),
    .frame_err (ferr_o[0]),
    .busy      (busy_o[0])
  );

  uart_ascii_rx #(
    .CLK_HZ      (CLK_HZ),
    .BAUD        (BAUD),
    .DIGITS_ONLY (1'b1),
    .RESET_CHAR  (8'h30)
  ) u_dut_dig (
    .clk       (clk),
    .rst_n     (rst_n),
    .rx        (rx),
    .ascii     (ascii_o[1]),
    .valid     (valid_o[1]),
    .frame_err (ferr_o[1]),
    .busy      (busy_o[1])
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (valid_o[i]) begin
        chk("valid_back_to_back", 32'(prev_v[i]), 32'd0);
        pulses[i]     = pulses[i] + 1;
        last_pulse[i] = cyc;
      end
    end
    prev_v = valid_o;
  end

  function automatic bit accepts(input int inst, input logic [7:0] b);
    return (inst == 0) || (b >= 8'h30 && b <= 8'h39);
  endfunction

  task automatic chk_reset(input string tag);
    for (int i = 0; i < 2; i++) begin
      chk({tag, "_ascii"}, 32'(ascii_o[i]), 32'h30);
      chk({tag, "_valid"}, 32'(valid_o[i]), 32'd0);
      chk({tag, "_ferr"},  32'(ferr_o[i]),  32'd0);
      chk({tag, "_busy"},  32'(busy_o[i]),  32'd0);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
  endtask

  // One 100-cycle frame; start bit driven just after an edge, line left high at the end.
  task automatic send_frame(input logic [7:0] b, input bit stop_ok);
    int t0;
    int d;
    bit acc;
    @(posedge clk); #1 rx = 1'b0;
    t0 = cyc;
    for (int k = 0; k < 8; k++) begin
      repeat (10) @(posedge clk);
      #1 rx = b[k];
    end
    repeat (10) @(posedge clk);
    #1 rx = stop_ok;
    repeat (8) @(posedge clk);
    for (int i = 0; i < 2; i++) begin
      acc = accepts(i, b) && stop_ok;
      if (stop_ok) exp_ferr[i] = 1'b0;
      else         exp_ferr[i] = 1'b1;
      if (acc) begin
        exp_ascii[i]  = b;
        exp_pulses[i] = exp_pulses[i] + 1;
      end
    end
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      chk("frame_valid", 32'(valid_o[i]), 32'(accepts(i, b) && stop_ok));
      chk("frame_ascii", 32'(ascii_o[i]), 32'(exp_ascii[i]));
      chk("frame_ferr",  32'(ferr_o[i]),  32'(exp_ferr[i]));
    end
    @(posedge clk); #1 rx = 1'b1;
    for (int i = 0; i < 2; i++) begin
      chk("pulse_count", 32'(pulses[i]), 32'(exp_pulses[i]));
      chk("busy_after_frame", 32'(busy_o[i]), 32'(!stop_ok));
      if (stop_ok && accepts(i, b)) begin
        d = last_pulse[i] - t0;
        chk("valid_latency_in_93_99", 32'(d >= 93 && d <= 99), 32'd1);
      end
    end
  endtask

  task automatic glitch3;
    @(posedge clk); #1 rx = 1'b0;
    repeat (3) @(posedge clk);
    #1 rx = 1'b1;
    repeat (7) @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      chk("glitch_busy",   32'(busy_o[i]),  32'd0);
      chk("glitch_ascii",  32'(ascii_o[i]), 32'(exp_ascii[i]));
      chk("glitch_pulses", 32'(pulses[i]),  32'(exp_pulses[i]));
    end
  endtask

  initial begin
    int         p1;
    int         g;
    bit         last_bad;
    bit         ok;
    logic [7:0] b;

    rst_n = 1'b0;
    rx    = 1'b1;
    repeat (5) @(posedge clk);
    #1 rst_n = 1'b1;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      chk_reset("reset_hold");
    end

    send_frame(8'h35, 1'b1);
    idle(20);

    send_frame(8'h37, 1'b1);
    p1 = last_pulse[0];
    send_frame(8'h39, 1'b1);
    chk("b2b_spacing_99_101", 32'((last_pulse[0] - p1) >= 99 && (last_pulse[0] - p1) <= 101), 32'd1);
    idle(10);

    glitch3();
    idle(5);

    send_frame(8'h32, 1'b0);
    idle(6);
    send_frame(8'h33, 1'b1);
    idle(10);

    send_frame(8'h41, 1'b1);
    send_frame(8'h34, 1'b1);
    idle(10);

    last_bad = 1'b0;
    for (int n = 0; n < 40; n++) begin
      if (last_bad)                     g = 4 + $urandom_range(0, 6);
      else if ($urandom_range(0, 2) == 0) g = 0;
      else                              g = $urandom_range(1, 20);
      idle(g);
      b  = ($urandom_range(0, 1) == 1) ? 8'($urandom_range(48, 57)) : 8'($urandom_range(0, 255));
      ok = ($urandom_range(0, 7) != 0);
      send_frame(b, ok);
      last_bad = !ok;
    end
    idle(10);

    @(posedge clk); #1 rx = 1'b0;
    repeat (10) @(posedge clk);
    #1 rx = 1'b0;
    repeat (25) @(posedge clk);
    #3 rst_n = 1'b0;
    rx = 1'b1;
    #1 chk_reset("reset_async");
    exp_ascii = '{8'h30, 8'h30};
    exp_ferr  = '{1'b0, 1'b0};
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (120) @(posedge clk);
    @(negedge clk);
    chk_reset("reset_after");
    for (int i = 0; i < 2; i++) begin
      chk("reset_no_pulse", 32'(pulses[i]), 32'(exp_pulses[i]));
    end

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
